inst_loader: RTL

//  Host-side initiator for the instruction-memory write port (IWEN/I_Addr/wInst) of Chip.

---
 rtl/inst_loader_if.sv | 28 ++
 rtl/inst_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/inst_loader_if.sv
// Host-side bundle for the instruction loader: control, byte stream and the
// Chip instruction-memory write port.
interface inst_loader_if #(
    parameter int AW = 7
);
    logic          start;
    logic [7:0]    word_count;
    logic          abort;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          IWEN;
    logic [AW-1:0] I_Addr;
    logic [31:0]   wInst;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, word_count, abort, s_valid, s_data,
        input  s_ready, IWEN, I_Addr, wInst, busy, done, err
    );

    modport slave (
        input  start, word_count, abort, s_valid, s_data,
        output s_ready, IWEN, I_Addr, wInst, busy, done, err
    );
endinterface

// File: rtl/inst_loader.sv
// Packs a byte stream into 32-bit words and writes them to Chip's instruction
// memory from address 0, holding IWEN high for the whole load.
module inst_loader #(
    parameter int DEPTH        = 128,
    parameter int AW           = $clog2(DEPTH),
    parameter int DRAIN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    inst_loader_if.slave bus
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DRAIN} state_t;

    state_t        state;
    logic [1:0]    rst_sync;
    logic          rst_n_i;
    logic [AW:0]   cnt;
    logic [AW:0]   wcnt;
    logic [1:0]    bcnt;
    logic [31:0]   pack;
    logic [DW-1:0] dcnt;
    logic          aborted;
    logic          s_ready_q;
    logic          iwen_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   inst_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          legal;

    // Asynchronous assert, synchronous release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    assign legal = (bus.word_count != 8'd0) && (int'(bus.word_count) <= DEPTH);

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            wcnt      <= '0;
            bcnt      <= '0;
            pack      <= '0;
            dcnt      <= '0;
            aborted   <= 1'b0;
            s_ready_q <= 1'b0;
            iwen_q    <= 1'b0;
            addr_q    <= '0;
            inst_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (legal) begin
                            state     <= LOAD;
                            cnt       <= (AW+1)'(bus.word_count);
                            wcnt      <= '0;
                            bcnt      <= '0;
                            pack      <= '0;
                            aborted   <= 1'b0;
                            iwen_q    <= 1'b1;
                            addr_q    <= '0;
                            inst_q    <= '0;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        pack      <= '0;
                        bcnt      <= '0;
                        aborted   <= 1'b1;
                        s_ready_q <= 1'b0;
                        dcnt      <= '0;
                        state     <= DRAIN;
                    end else if (bus.s_valid && s_ready_q) begin
                        // First byte ends up in the top lane after four shifts.
                        pack <= {pack[23:0], bus.s_data};
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            // Address and data move on the same edge so Chip only sees valid pairs.
                            inst_q    <= {pack[23:0], bus.s_data};
                            addr_q    <= wcnt[AW-1:0];
                            wcnt      <= wcnt + 1'b1;
                            pack      <= '0;
                            s_ready_q <= 1'b0;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.abort || (wcnt == cnt)) begin
                        aborted <= aborted | bus.abort;
                        dcnt    <= '0;
                        state   <= DRAIN;
                    end else begin
                        s_ready_q <= 1'b1;
                        state     <= LOAD;
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(DRAIN_CYCLES - 1)) begin
                        iwen_q <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= aborted;
                        state  <= IDLE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.IWEN    = iwen_q;
    assign bus.I_Addr  = addr_q;
    assign bus.wInst   = inst_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule
